// File: rtl/bitty_param_core_if.sv
// Instruction fetch handshake and retire reporting between an instruction
// source (master) and the BittyPro core (slave).
interface bitty_param_core_if;
   logic        inst_valid;
   logic        inst_ready;
   logic [15:0] instruction;
   logic        done;
   logic        illegal;

   modport master (
      output inst_valid,
      output instruction,
      input  inst_ready,
      input  done,
      input  illegal
   );

   modport slave (
      input  inst_valid,
      input  instruction,
      output inst_ready,
      output done,
      output illegal
   );
endinterface

// File: rtl/bitty_param_core.sv
// BittyPro datapath/controller: one 16-bit instruction at a time over an
// 8-entry register file. Sequence per instruction is IDLE -> LOAD -> EXEC ->
// WB, or IDLE -> ERR for an illegal format.
module bitty_param_core #(
   parameter int DATA_W     = 16,
   parameter bit CMP_SIGNED = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   bitty_param_core_if.slave     bus,
   output logic [8*DATA_W-1:0]   regs_flat,
   output logic [DATA_W-1:0]     reg_C,
   output logic                  flag_z,
   output logic                  flag_c
);

   localparam int SHW = $clog2(DATA_W);

   typedef enum logic [2:0] {IDLE, LOAD, EXEC, WB, ERR} state_t;

   state_t              state_q, state_d;
   logic [15:0]         instr_q;
   logic [DATA_W-1:0]   regs_q [8];
   logic [DATA_W-1:0]   regS_q;
   logic [DATA_W-1:0]   regB_q;
   logic [DATA_W-1:0]   regC_q;
   logic                z_q;
   logic                c_q;

   logic [2:0]          rx, ry, op;
   logic [1:0]          fmt;
   logic [DATA_W-1:0]   b_dec;
   logic [DATA_W:0]     alu_res;

   // ALU: returns {carry/borrow, result}; results wrap modulo 2^DATA_W.
   function automatic logic [DATA_W:0] alu(input logic [2:0]        fop,
                                           input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b);
      logic signed [DATA_W-1:0] sa;
      logic signed [DATA_W-1:0] sb;
      logic                     gt;
      logic                     lt;
      logic [DATA_W:0]          r;
      sa = a;
      sb = b;
      if (CMP_SIGNED) begin
         gt = sa > sb;
         lt = sa < sb;
      end else begin
         gt = a > b;
         lt = a < b;
      end
      case (fop)
         3'd0:    r = {1'b0, a} + {1'b0, b};
         3'd1:    r = {1'b0, a} - {1'b0, b};   // top bit is the borrow
         3'd2:    r = {1'b0, a & b};
         3'd3:    r = {1'b0, a | b};
         3'd4:    r = {1'b0, a ^ b};
         3'd5:    r = {1'b0, a << b[SHW-1:0]};
         3'd6:    r = {1'b0, a >> b[SHW-1:0]};
         default: r = {1'b0, lt ? DATA_W'(2) : (gt ? DATA_W'(1) : {DATA_W{1'b0}})};
      endcase
      return r;
   endfunction

   assign rx  = instr_q[15:13];
   assign ry  = instr_q[12:10];
   assign op  = instr_q[4:2];
   assign fmt = instr_q[1:0];

   // Operand B: zero-extended imm8 for fmt 01, otherwise R[ry].
   always_comb begin
      b_dec = regs_q[ry];
      if (fmt == 2'b01) begin
         b_dec = DATA_W'(instr_q[12:5]);
      end
   end

   assign alu_res = alu(op, regS_q, regB_q);

   // Next-state decode; only IDLE looks at the handshake inputs.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.inst_valid) state_d = bus.instruction[1] ? ERR : LOAD;
         LOAD:    state_d = EXEC;
         EXEC:    state_d = WB;
         WB:      state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Datapath registers, each loaded in the state that owns it.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= '0;
         regS_q  <= '0;
         regB_q  <= '0;
         regC_q  <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         for (int n = 0; n < 8; n++) regs_q[n] <= '0;
      end else begin
         case (state_q)
            // accept: latch the instruction word
            IDLE: if (bus.inst_valid) instr_q <= bus.instruction;
            // operand fetch: both operands captured before any write-back
            LOAD: begin
               regS_q <= regs_q[rx];
               regB_q <= b_dec;
            end
            // execute: result and flags update together
            EXEC: begin
               regC_q <= alu_res[DATA_W-1:0];
               c_q    <= alu_res[DATA_W] & (op == 3'd0 || op == 3'd1);
               z_q    <= (alu_res[DATA_W-1:0] == '0);
            end
            // write-back
            WB:   regs_q[rx] <= regC_q;
            default: ;
         endcase
      end
   end

   assign bus.inst_ready = (state_q == IDLE);
   assign bus.done       = (state_q == WB) || (state_q == ERR);
   assign bus.illegal    = (state_q == ERR);

   for (genvar g = 0; g < 8; g++) begin : g_flat
      assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign reg_C  = regC_q;
   assign flag_z = z_q;
   assign flag_c = c_q;

endmodule

// File: tb/tb_bitty_param_core.sv
// Scoreboard bench for bitty_param_core: a 16-bit unsigned-CMP instance and an
// 8-bit signed-CMP instance, each with its own expected-response queue.
module tb_bitty_param_core;

   typedef struct packed {
      logic [15:0] res;
      logic        z;
      logic        c;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst16, rst8;
   logic [127:0] rf16;
   logic [63:0]  rf8;
   logic [15:0] rc16;
   logic [7:0]  rc8;
   logic        z16, c16, z8, c8;

   bitty_param_core_if b16 ();
   bitty_param_core_if b8 ();

   bitty_param_core #(.DATA_W(16), .CMP_SIGNED(1'b0)) u16 (
      .clk(clk), .reset(rst16), .bus(b16),
      .regs_flat(rf16), .reg_C(rc16), .flag_z(z16), .flag_c(c16)
   );

   bitty_param_core #(.DATA_W(8), .CMP_SIGNED(1'b1)) u8 (
      .clk(clk), .reset(rst8), .bus(b8),
      .regs_flat(rf8), .reg_C(rc8), .flag_z(z8), .flag_c(c8)
   );

   int   nvec = 0;
   int   nfail = 0;
   int   cyc = 0;
   int   dn16 = 0;
   exp_t q16[$];
   exp_t q8[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   function automatic logic [15:0] enc_i(input logic [2:0] rx, input logic [7:0] imm,
                                         input logic [2:0] op);
      return {rx, imm, op, 2'b01};
   endfunction

   function automatic logic [15:0] enc_r(input logic [2:0] rx, input logic [2:0] ry,
                                         input logic [2:0] op);
      return {rx, ry, 5'b00000, op, 2'b00};
   endfunction

   // Monitors: pop and compare whenever a core retires.
   always @(negedge clk) begin
      exp_t e;
      if (b16.done) begin
         dn16++;
         if (q16.size() == 0) begin
            chk("u16 unexpected done", 32'(b16.done), 32'd0);
         end else begin
            e = q16.pop_front();
            chk("u16 reg_C", 32'(rc16), 32'(e.res));
            chk("u16 flag_z", 32'(z16), 32'(e.z));
            chk("u16 flag_c", 32'(c16), 32'(e.c));
            chk("u16 illegal", 32'(b16.illegal), 32'(e.ill));
         end
      end else if (b16.illegal) begin
         chk("u16 illegal without done", 32'(b16.illegal), 32'd0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (b8.done) begin
         if (q8.size() == 0) begin
            chk("u8 unexpected done", 32'(b8.done), 32'd0);
         end else begin
            e = q8.pop_front();
            chk("u8 reg_C", 32'(rc8), 32'(e.res));
            chk("u8 flag_z", 32'(z8), 32'(e.z));
            chk("u8 flag_c", 32'(c8), 32'(e.c));
            chk("u8 illegal", 32'(b8.illegal), 32'(e.ill));
         end
      end
   end

   // Offer w (called at a negedge); returns at the negedge after the accept edge.
   task automatic send16(input logic [15:0] w, input exp_t e, input bit push, output int acc);
      int t = 0;
      b16.inst_valid  = 1'b1;
      b16.instruction = w;
      while (!b16.inst_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      acc = cyc;
      if (!b16.inst_ready) begin
         chk("u16 accept timeout", 32'(t), 32'd0);
      end else begin
         if (push) q16.push_back(e);
         @(negedge clk);
      end
   endtask

   task automatic send8(input logic [15:0] w, input exp_t e);
      int t = 0;
      b8.inst_valid  = 1'b1;
      b8.instruction = w;
      while (!b8.inst_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!b8.inst_ready) begin
         chk("u8 accept timeout", 32'(t), 32'd0);
      end else begin
         q8.push_back(e);
         @(negedge clk);
      end
   endtask

   task automatic idle16();
      int t = 0;
      b16.inst_valid = 1'b0;
      do begin
         @(negedge clk);
         t++;
      end while ((!b16.inst_ready || q16.size() != 0) && t < 50);
      if (t >= 50) chk("u16 idle timeout", 32'(t), 32'd0);
   endtask

   task automatic idle8();
      int t = 0;
      b8.inst_valid = 1'b0;
      do begin
         @(negedge clk);
         t++;
      end while ((!b8.inst_ready || q8.size() != 0) && t < 50);
      if (t >= 50) chk("u8 idle timeout", 32'(t), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, a2, d0;
      rst16 = 1'b1;
      rst8  = 1'b1;
      b16.inst_valid  = 1'b0;
      b16.instruction = '0;
      b8.inst_valid   = 1'b0;
      b8.instruction  = '0;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst ready", 32'(b16.inst_ready), 32'd1);
      chk("rst done", 32'(b16.done), 32'd0);
      chk("rst regs", 32'(rf16 != '0), 32'd0);
      chk("rst reg_C/flags", {rc16, 14'd0, z16, c16}, 32'd0);
      rst16 = 1'b0;
      rst8  = 1'b0;
      @(negedge clk);

      // ADDI r1,#5: ready low 3 cycles, done on the 3rd
      send16(16'h20A1, '{res: 16'd5, z: 1'b0, c: 1'b0, ill: 1'b0}, 1'b1, a0);
      b16.inst_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("t1 ready low", 32'(b16.inst_ready), 32'd0);
         chk("t1 done timing", 32'(b16.done), 32'(k == 2));
         @(negedge clk);
      end
      chk("t1 ready back", 32'(b16.inst_ready), 32'd1);
      chk("t1 R1", 32'(rf16[16 +: 16]), 32'd5);

      // SUB r3,r1 then CMP r1,r3 (unsigned)
      send16(enc_r(3'd3, 3'd1, 3'd1), '{res: 16'hFFFB, z: 1'b0, c: 1'b1, ill: 1'b0}, 1'b1, a0);
      idle16();
      chk("t3 R3", 32'(rf16[48 +: 16]), 32'h0000FFFB);
      send16(enc_r(3'd1, 3'd3, 3'd7), '{res: 16'd2, z: 1'b0, c: 1'b0, ill: 1'b0}, 1'b1, a0);
      idle16();
      chk("t3 R1 cmp", 32'(rf16[16 +: 16]), 32'd2);

      // three back-to-back with valid held high
      d0 = dn16;
      send16(enc_i(3'd2, 8'h0F, 3'd0), '{res: 16'h000F, z: 1'b0, c: 1'b0, ill: 1'b0}, 1'b1, a0);
      send16(enc_i(3'd2, 8'd4,  3'd5), '{res: 16'h00F0, z: 1'b0, c: 1'b0, ill: 1'b0}, 1'b1, a1);
      send16(enc_i(3'd2, 8'd8,  3'd6), '{res: 16'h0000, z: 1'b1, c: 1'b0, ill: 1'b0}, 1'b1, a2);
      idle16();
      chk("t4 spacing 1", 32'(a1 - a0), 32'd4);
      chk("t4 spacing 2", 32'(a2 - a1), 32'd4);
      chk("t4 done count", 32'(dn16 - d0), 32'd3);
      chk("t4 R2", 32'(rf16[32 +: 16]), 32'd0);

      // illegal fmt 10: reg_C/flags held from the SHR above
      send16(16'h2002, '{res: 16'h0000, z: 1'b1, c: 1'b0, ill: 1'b1}, 1'b1, a0);
      b16.inst_valid = 1'b0;
      chk("t5 illegal pulse", {31'd0, b16.illegal}, 32'd1);
      @(negedge clk);
      chk("t5 ready after err", 32'(b16.inst_ready), 32'd1);
      chk("t5 pulse ended", {30'd0, b16.done, b16.illegal}, 32'd0);
      chk("t5 R1", 32'(rf16[16 +: 16]), 32'd2);
      chk("t5 R3", 32'(rf16[48 +: 16]), 32'h0000FFFB);
      chk("t5 reg_C/flags", {rc16, 14'd0, z16, c16}, 32'h00000002);

      // reset during EXEC of ADDI r4,#9
      send16(enc_i(3'd4, 8'd9, 3'd0), '0, 1'b0, a0);
      b16.inst_valid = 1'b0;
      @(negedge clk);
      rst16 = 1'b1;
      @(negedge clk);
      chk("t6 done in reset", 32'(b16.done), 32'd0);
      rst16 = 1'b0;
      @(negedge clk);
      chk("t6 ready", 32'(b16.inst_ready), 32'd1);
      chk("t6 regs zero", 32'(rf16 != '0), 32'd0);
      chk("t6 reg_C/flags", {rc16, 14'd0, z16, c16}, 32'd0);
      repeat (4) @(negedge clk);

      // DATA_W = 8: wrap, carry, zero; signed CMP
      send8(enc_i(3'd2, 8'hFF, 3'd0), '{res: 16'h00FF, z: 1'b0, c: 1'b0, ill: 1'b0});
      send8(enc_i(3'd2, 8'h01, 3'd0), '{res: 16'h0000, z: 1'b1, c: 1'b1, ill: 1'b0});
      idle8();
      chk("t2 R2", 32'(rf8[16 +: 8]), 32'd0);
      chk("t2 flags", {30'd0, z8, c8}, 32'd3);
      send8(enc_i(3'd3, 8'h80, 3'd0), '{res: 16'h0080, z: 1'b0, c: 1'b0, ill: 1'b0});
      send8(enc_r(3'd2, 3'd3, 3'd7), '{res: 16'h0001, z: 1'b0, c: 1'b0, ill: 1'b0});
      idle8();
      chk("t2 signed cmp R2", 32'(rf8[16 +: 8]), 32'd1);

      chk("u16 queue drained", 32'(q16.size()), 32'd0);
      chk("u8 queue drained", 32'(q8.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
